// File: rtl/spinnaker_fpgas_diag_reg_bank_pkg.sv
// Shared definitions for the diagnostic register bank: word address map and
// the decode selector used by the bank's request path.
package spinnaker_fpgas_diag_reg_bank_pkg;

  localparam int ADDR_VERS      = 'h00;
  localparam int ADDR_FLAG      = 'h01;
  localparam int ADDR_STKY      = 'h02;
  localparam int ADDR_IRQEN     = 'h03;
  localparam int ADDR_CCLR      = 'h04;
  localparam int ADDR_CTRL_BASE = 'h10;
  localparam int ADDR_CNT_BASE  = 'h20;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_VERS,
    SEL_FLAG,
    SEL_STKY,
    SEL_IRQEN,
    SEL_CCLR,
    SEL_CTRL,
    SEL_CNT
  } sel_e;

endpackage

// File: rtl/spinnaker_fpgas_sat_counter.sv
// Saturating event counter: clear wins over increment, holds at all ones, and
// flags the single cycle in which the count is about to reach saturation.
module spinnaker_fpgas_sat_counter #(
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                clr,
  output logic [CNT_BITS-1:0] count,
  output logic                sat_hit
);

  logic                saturated;
  logic [CNT_BITS-1:0] count_inc;

  assign saturated = &count;
  assign count_inc = count + 1'b1;
  // High only on the increment that lands on all ones, so sticky flags set once.
  assign sat_hit   = inc & ~clr & ~saturated & (&count_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !saturated) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/spinnaker_fpgas_diag_reg_bank.sv
// Control/diagnostic register bank: RW control registers with byte strobes,
// saturating event counters with sticky flags and IRQ, valid/ready access port.
module spinnaker_fpgas_diag_reg_bank
  import spinnaker_fpgas_diag_reg_bank_pkg::*;
#(
  parameter int REGA_BITS = 14,
  parameter int REGD_BITS = 32,
  parameter int NUM_CTRL  = 6,
  parameter int NUM_CNT   = 8,
  parameter int CNT_BITS  = 32,
  parameter logic [NUM_CTRL*REGD_BITS-1:0] CTRL_RESET = {NUM_CTRL{{REGD_BITS{1'b1}}}}
) (
  input  logic                          CLK_IN,
  input  logic                          RESET_N_IN,
  input  logic                          REQ_VLD_IN,
  output logic                          REQ_RDY_OUT,
  input  logic                          REQ_WRITE_IN,
  input  logic [REGA_BITS-1:0]          REQ_ADDR_IN,
  input  logic [REGD_BITS-1:0]          REQ_WDATA_IN,
  input  logic [REGD_BITS/8-1:0]        REQ_WSTRB_IN,
  output logic                          RSP_VLD_OUT,
  input  logic                          RSP_RDY_IN,
  output logic [REGD_BITS-1:0]          RSP_RDATA_OUT,
  input  logic [REGD_BITS-1:0]          VERSION_IN,
  input  logic [REGD_BITS-1:0]          FLAGS_IN,
  input  logic [NUM_CNT-1:0]            EVENT_IN,
  output logic [NUM_CTRL*REGD_BITS-1:0] CTRL_OUT,
  output logic                          IRQ_OUT
);

  localparam int STRB_BITS = REGD_BITS / 8;
  localparam logic [REGD_BITS-1:0] RD_DEFAULT = {REGD_BITS{1'b1}};

  logic [NUM_CTRL-1:0][REGD_BITS-1:0] ctrl_q;
  logic [NUM_CNT-1:0][CNT_BITS-1:0]   cnt_val;
  logic [NUM_CNT-1:0]                 stky_q;
  logic [NUM_CNT-1:0]                 irq_en_q;
  logic [NUM_CNT-1:0]                 cnt_hit;
  logic [NUM_CNT-1:0]                 cnt_clr;
  logic [NUM_CNT-1:0]                 stky_w1c;
  logic [NUM_CTRL-1:0]                ctrl_sel;
  logic [NUM_CNT-1:0]                 cnt_sel;
  logic [REGD_BITS-1:0]               rd_data;
  logic [REGD_BITS-1:0]               rsp_rdata_q;
  logic                               rsp_vld_q;
  logic                               irq_q;
  logic                               accept;
  logic                               wr_en;
  sel_e                               sel;

  assign REQ_RDY_OUT   = !rsp_vld_q || RSP_RDY_IN;
  assign accept        = REQ_VLD_IN && REQ_RDY_OUT;
  assign wr_en         = accept && REQ_WRITE_IN;
  assign RSP_VLD_OUT   = rsp_vld_q;
  assign RSP_RDATA_OUT = rsp_rdata_q;
  assign CTRL_OUT      = ctrl_q;
  assign IRQ_OUT       = irq_q;

  always_comb begin
    sel      = SEL_NONE;
    ctrl_sel = '0;
    cnt_sel  = '0;
    if (REQ_ADDR_IN == REGA_BITS'(ADDR_VERS))       sel = SEL_VERS;
    else if (REQ_ADDR_IN == REGA_BITS'(ADDR_FLAG))  sel = SEL_FLAG;
    else if (REQ_ADDR_IN == REGA_BITS'(ADDR_STKY))  sel = SEL_STKY;
    else if (REQ_ADDR_IN == REGA_BITS'(ADDR_IRQEN)) sel = SEL_IRQEN;
    else if (REQ_ADDR_IN == REGA_BITS'(ADDR_CCLR))  sel = SEL_CCLR;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (REQ_ADDR_IN == REGA_BITS'(ADDR_CTRL_BASE + i)) begin
        sel         = SEL_CTRL;
        ctrl_sel[i] = 1'b1;
      end
    end
    for (int j = 0; j < NUM_CNT; j++) begin
      if (REQ_ADDR_IN == REGA_BITS'(ADDR_CNT_BASE + j)) begin
        sel        = SEL_CNT;
        cnt_sel[j] = 1'b1;
      end
    end
  end

  // Counter reads see the registered value, i.e. before this cycle's increment.
  always_comb begin
    rd_data = RD_DEFAULT;
    case (sel)
      SEL_VERS:  rd_data = VERSION_IN;
      SEL_FLAG:  rd_data = FLAGS_IN;
      SEL_STKY:  rd_data = REGD_BITS'(stky_q);
      SEL_IRQEN: rd_data = REGD_BITS'(irq_en_q);
      SEL_CCLR:  rd_data = '0;
      SEL_CTRL: begin
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (ctrl_sel[i]) rd_data = ctrl_q[i];
        end
      end
      SEL_CNT: begin
        for (int j = 0; j < NUM_CNT; j++) begin
          if (cnt_sel[j]) rd_data = REGD_BITS'(cnt_val[j]);
        end
      end
      default: rd_data = RD_DEFAULT;
    endcase
  end

  assign stky_w1c = (wr_en && sel == SEL_STKY) ? REQ_WDATA_IN[NUM_CNT-1:0] : '0;
  assign cnt_clr  = (wr_en && sel == SEL_CCLR) ? REQ_WDATA_IN[NUM_CNT-1:0] : '0;

  for (genvar j = 0; j < NUM_CNT; j++) begin : g_cnt
    spinnaker_fpgas_sat_counter #(
      .CNT_BITS(CNT_BITS)
    ) u_cnt (
      .clk    (CLK_IN),
      .rst_n  (RESET_N_IN),
      .inc    (EVENT_IN[j]),
      .clr    (cnt_clr[j]),
      .count  (cnt_val[j]),
      .sat_hit(cnt_hit[j])
    );
  end

  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      ctrl_q <= CTRL_RESET;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        for (int b = 0; b < STRB_BITS; b++) begin
          if (ctrl_sel[i] && REQ_WSTRB_IN[b]) ctrl_q[i][b*8 +: 8] <= REQ_WDATA_IN[b*8 +: 8];
        end
      end
    end
  end

  // A saturation event in the same cycle as a W1C keeps the sticky bit set.
  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      stky_q   <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      stky_q <= (stky_q & ~stky_w1c) | cnt_hit;
      if (wr_en && sel == SEL_IRQEN) irq_en_q <= REQ_WDATA_IN[NUM_CNT-1:0];
      irq_q <= |(stky_q & irq_en_q);
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (accept) begin
      rsp_vld_q   <= 1'b1;
      rsp_rdata_q <= REQ_WRITE_IN ? '0 : rd_data;
    end else if (RSP_RDY_IN) begin
      rsp_vld_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spinnaker_fpgas_diag_reg_bank.sv
// Bench for the diagnostic register bank: directed scenarios with literal
// expectations plus a randomized phase, all checked against a transaction model.
module tb_spinnaker_fpgas_diag_reg_bank;

  localparam int NCTRL = 6;
  localparam int NCNT  = 8;
  localparam int CMAX  = 15;
  localparam logic [NCTRL*32-1:0] CRST =
    {32'h66666666, 32'h55555555, 32'h44444444, 32'hFFFFFFFF, 32'h22222222, 32'h11111111};
  localparam logic [31:0] VERS = 32'h0102_0304;
  localparam logic [31:0] FLGS = 32'hCAFE_F00D;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_vld = 1'b0;
  logic              req_rdy;
  logic              req_write = 1'b0;
  logic [13:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic [3:0]        req_wstrb = '0;
  logic              rsp_vld;
  logic              rsp_rdy = 1'b1;
  logic [31:0]       rsp_rdata;
  logic [31:0]       version = VERS;
  logic [31:0]       flags = FLGS;
  logic [NCNT-1:0]   event_in = '0;
  logic [NCTRL*32-1:0] ctrl_out;
  logic              irq;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  spinnaker_fpgas_diag_reg_bank #(
    .REGA_BITS (14),
    .REGD_BITS (32),
    .NUM_CTRL  (NCTRL),
    .NUM_CNT   (NCNT),
    .CNT_BITS  (4),
    .CTRL_RESET(CRST)
  ) dut (
    .CLK_IN       (clk),
    .RESET_N_IN   (rst_n),
    .REQ_VLD_IN   (req_vld),
    .REQ_RDY_OUT  (req_rdy),
    .REQ_WRITE_IN (req_write),
    .REQ_ADDR_IN  (req_addr),
    .REQ_WDATA_IN (req_wdata),
    .REQ_WSTRB_IN (req_wstrb),
    .RSP_VLD_OUT  (rsp_vld),
    .RSP_RDY_IN   (rsp_rdy),
    .RSP_RDATA_OUT(rsp_rdata),
    .VERSION_IN   (version),
    .FLAGS_IN     (flags),
    .EVENT_IN     (event_in),
    .CTRL_OUT     (ctrl_out),
    .IRQ_OUT      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents as plain arrays and integers.
  int unsigned m_cnt [NCNT];
  bit [31:0]   m_ctrl[NCTRL];
  bit [7:0]    m_stky, m_irqen;
  bit          m_irq, m_rsp_vld;
  bit [31:0]   m_rsp_data;

  function automatic bit [31:0] model_read(input int a);
    if (a == 0) return VERS;
    if (a == 1) return FLGS;
    if (a == 2) return {24'h0, m_stky};
    if (a == 3) return {24'h0, m_irqen};
    if (a == 4) return 32'h0;
    if (a >= 'h10 && a < 'h10 + NCTRL) return m_ctrl[a - 'h10];
    if (a >= 'h20 && a < 'h20 + NCNT) return m_cnt[a - 'h20];
    return 32'hFFFF_FFFF;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCTRL; i++) m_ctrl[i] = CRST[i*32 +: 32];
      for (int j = 0; j < NCNT; j++) m_cnt[j] = 0;
      m_stky = 0; m_irqen = 0; m_irq = 0; m_rsp_vld = 0; m_rsp_data = 0;
    end else begin
      bit        acc;
      bit [31:0] rd;
      bit [7:0]  w1c, clr, setv;
      int        a;
      a    = int'(req_addr);
      acc  = req_vld && (!m_rsp_vld || rsp_rdy);
      rd   = model_read(a);
      m_irq = |(m_stky & m_irqen);
      w1c = 0; clr = 0; setv = 0;
      if (acc && req_write) begin
        if (a == 2) w1c = req_wdata[7:0];
        if (a == 3) m_irqen = req_wdata[7:0];
        if (a == 4) clr = req_wdata[7:0];
        if (a >= 'h10 && a < 'h10 + NCTRL)
          for (int b = 0; b < 4; b++)
            if (req_wstrb[b]) m_ctrl[a - 'h10][b*8 +: 8] = req_wdata[b*8 +: 8];
      end
      for (int j = 0; j < NCNT; j++) begin
        if (clr[j]) m_cnt[j] = 0;
        else if (event_in[j] && m_cnt[j] < CMAX) begin
          m_cnt[j]++;
          if (m_cnt[j] == CMAX) setv[j] = 1'b1;
        end
      end
      m_stky = (m_stky & ~w1c) | setv;
      if (acc) begin
        m_rsp_vld  = 1'b1;
        m_rsp_data = req_write ? 32'h0 : rd;
      end else if (rsp_rdy) begin
        m_rsp_vld = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_rsp_vld", {31'h0, rsp_vld}, {31'h0, m_rsp_vld});
      check("cmp_req_rdy", {31'h0, req_rdy}, {31'h0, (!m_rsp_vld || rsp_rdy)});
      check("cmp_irq", {31'h0, irq}, {31'h0, m_irq});
      if (m_rsp_vld) check("cmp_rsp_rdata", rsp_rdata, m_rsp_data);
      for (int i = 0; i < NCTRL; i++) check("cmp_ctrl_out", ctrl_out[i*32 +: 32], m_ctrl[i]);
    end
  end

  task automatic xfer(input bit w, input logic [13:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [NCNT-1:0] ev, output logic [31:0] rd);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    req_vld = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s; event_in = ev;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_rdy) got = 1'b1;
    end
    check("xfer_accept", {31'h0, got}, 32'h1);
    @(posedge clk); #1;
    req_vld = 1'b0; event_in = '0;
    @(negedge clk);
    rd = rsp_rdata;
    check("xfer_rsp_vld", {31'h0, rsp_vld}, 32'h1);
  endtask

  task automatic rd_chk(input string name, input logic [13:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    xfer(1'b0, a, 32'h0, 4'h0, '0, rd);
    check(name, rd, exp);
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [NCNT-1:0] ev);
    logic [31:0] rd;
    xfer(1'b1, a, d, s, ev, rd);
    check("wr_rsp_zero", rd, 32'h0);
  endtask

  task automatic pulse(input logic [NCNT-1:0] ev, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      event_in = ev;
    end
    @(posedge clk); #1;
    event_in = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_b2b [4];
    logic [31:0] held;
    bit          acc;

    rst_n = 1'b0;
    #1;
    check("reset_rdy", {31'h0, req_rdy}, 32'h1);
    check("reset_rsp_vld", {31'h0, rsp_vld}, 32'h0);
    check("reset_rdata", rsp_rdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset values through the read port
    rd_chk("rd_vers", 14'h00, VERS);
    rd_chk("rd_flag", 14'h01, FLGS);
    rd_chk("rd_stky", 14'h02, 32'h0);
    rd_chk("rd_irqen", 14'h03, 32'h0);
    rd_chk("rd_cclr", 14'h04, 32'h0);
    for (int i = 0; i < NCTRL; i++) rd_chk("rd_ctrl_rst", 14'(16 + i), CRST[i*32 +: 32]);
    for (int j = 0; j < NCNT; j++) rd_chk("rd_cnt_rst", 14'(32 + j), 32'h0);
    rd_chk("rd_unmapped_05", 14'h05, 32'hFFFF_FFFF);
    rd_chk("rd_unmapped_16", 14'h16, 32'hFFFF_FFFF);
    rd_chk("rd_unmapped_28", 14'h28, 32'hFFFF_FFFF);
    rd_chk("rd_unmapped_hi", 14'h3FFF, 32'hFFFF_FFFF);

    // Byte-strobed control write
    wr(14'h12, 32'hA5A5_A5A5, 4'b0101, '0);
    check("ctrl_out_2", ctrl_out[2*32 +: 32], 32'hFFA5_FFA5);
    rd_chk("rd_ctrl2_strb", 14'h12, 32'hFFA5_FFA5);
    wr(14'h00, 32'h1234_5678, 4'hF, '0);
    rd_chk("rd_vers_ro", 14'h00, VERS);

    // Saturation, sticky flag and IRQ
    pulse(8'h08, 15);
    pulse(8'h08, 3);
    rd_chk("rd_cnt3_sat", 14'h23, 32'h0000_000F);
    rd_chk("rd_stky_sat", 14'h02, 32'h0000_0008);
    wr(14'h03, 32'h0000_0008, 4'h0, '0);
    @(negedge clk);
    check("irq_set", {31'h0, irq}, 32'h1);
    wr(14'h02, 32'h0000_0008, 4'h0, '0);
    check("irq_hold_one_cycle", {31'h0, irq}, 32'h1);
    @(negedge clk);
    check("irq_clear", {31'h0, irq}, 32'h0);
    rd_chk("rd_stky_w1c", 14'h02, 32'h0);

    // Clear vs increment, W1C vs saturation
    pulse(8'h01, 3);
    rd_chk("rd_cnt0_pre", 14'h20, 32'h3);
    wr(14'h04, 32'h0000_0001, 4'h0, 8'h01);
    rd_chk("rd_cnt0_clr", 14'h20, 32'h0);
    pulse(8'h02, 14);
    wr(14'h02, 32'h0000_0002, 4'h0, 8'h02);
    rd_chk("rd_stky_keep", 14'h02, 32'h0000_0002);
    rd_chk("rd_cnt1_sat", 14'h21, 32'h0000_000F);
    rd_chk("rd_cclr_zero", 14'h04, 32'h0);

    // Response back-pressure then back-to-back reads
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    req_vld = 1'b1; req_write = 1'b0; req_addr = 14'h00;
    @(posedge clk); #1;
    req_addr = 14'h01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_vld", {31'h0, rsp_vld}, 32'h1);
      check("stall_rdy", {31'h0, req_rdy}, 32'h0);
      check("stall_data", rsp_rdata, VERS);
      @(posedge clk); #1;
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    check("release_rdy", {31'h0, req_rdy}, 32'h1);
    @(posedge clk); #1;
    req_addr = 14'h10;
    @(negedge clk);
    check("release_data", rsp_rdata, FLGS);
    exp_b2b[0] = 32'h1111_1111; exp_b2b[1] = 32'h2222_2222;
    exp_b2b[2] = 32'hFFA5_FFA5; exp_b2b[3] = 32'h4444_4444;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k < 3) req_addr = 14'(17 + k);
      else req_vld = 1'b0;
      @(negedge clk);
      check("b2b_vld", {31'h0, rsp_vld}, 32'h1);
      check("b2b_data", rsp_rdata, exp_b2b[k]);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc = req_vld && req_rdy;
      @(posedge clk); #1;
      if (!req_vld || acc) begin
        req_vld   = ($urandom_range(0, 3) != 0);
        req_write = $urandom_range(0, 1);
        case ($urandom_range(0, 3))
          0: req_addr = 14'($urandom_range(0, 5));
          1: req_addr = 14'($urandom_range('h10, 'h16));
          2: req_addr = 14'($urandom_range('h20, 'h28));
          default: req_addr = 14'($urandom);
        endcase
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
      end
      rsp_rdy  = ($urandom_range(0, 3) != 0);
      event_in = 8'($urandom) & 8'($urandom);
    end
    @(posedge clk); #1;
    req_vld = 1'b0; event_in = '0; rsp_rdy = 1'b1;
    repeat (2) @(posedge clk);

    // Reset with a response pending
    #1;
    wr(14'h12, 32'h0000_0000, 4'hF, '0);
    pulse(8'h02, 16);
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    req_vld = 1'b1; req_write = 1'b0; req_addr = 14'h00;
    @(posedge clk); #1;
    req_vld = 1'b0;
    @(negedge clk);
    check("pend_vld", {31'h0, rsp_vld}, 32'h1);
    held = rsp_rdata;
    check("pend_data", held, VERS);
    #2 rst_n = 1'b0;
    #1;
    check("rst_vld_drop", {31'h0, rsp_vld}, 32'h0);
    check("rst_rdy", {31'h0, req_rdy}, 32'h1);
    check("rst_ctrl2", ctrl_out[2*32 +: 32], 32'hFFFF_FFFF);
    check("rst_irq", {31'h0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_rdy = 1'b1;
    rd_chk("rd_cnt1_after_rst", 14'h21, 32'h0);
    rd_chk("rd_stky_after_rst", 14'h02, 32'h0);
    rd_chk("rd_ctrl2_after_rst", 14'h12, 32'hFFFF_FFFF);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
